nonce_scanner: RTL

Upstream job sequencer for the double-SHA-256 header hash core. It accepts one mining job (header fields, compact target, nonce range) and assembles each 640-bit header. It presents headers to the hash core one at a time with a valid/ready handshake and compares every returned digest against the expanded target. It reports the first qualifying nonce, or range exhaustion.

---
 rtl/mining_pkg.sv | 42 ++++
 rtl/target_expand.sv | 27 ++
 rtl/nonce_scanner.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mining_pkg.sv
// Shared types, header field offsets and byte-order helpers for the mining job path.
package mining_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK
  } state_t;

  localparam int unsigned HDR_W       = 640;
  localparam int unsigned VERSION_MSB = 639;
  localparam int unsigned PREV_MSB    = 607;
  localparam int unsigned MERKLE_MSB  = 351;
  localparam int unsigned TIME_MSB    = 95;
  localparam int unsigned BITS_MSB    = 63;
  localparam int unsigned NONCE_MSB   = 31;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [HDR_W-1:0] build_header(
    input logic [31:0]  version,
    input logic [255:0] prev_hash,
    input logic [255:0] merkle,
    input logic [31:0]  time_f,
    input logic [31:0]  bits,
    input logic [31:0]  nonce
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[VERSION_MSB -: 32]  = bswap32(version);
    h[PREV_MSB    -: 256] = prev_hash;
    h[MERKLE_MSB  -: 256] = merkle;
    h[TIME_MSB    -: 32]  = bswap32(time_f);
    h[BITS_MSB    -: 32]  = bswap32(bits);
    h[NONCE_MSB   -: 32]  = bswap32(nonce);
    return h;
  endfunction

endpackage

// File: rtl/target_expand.sv
// Combinational expansion of a compact (nBits) target into its 256-bit integer form.
module target_expand (
  input  logic [31:0]  i_bits,
  output logic [255:0] o_target
);

  logic [7:0]   w_exp;
  logic [255:0] w_mant;
  logic [10:0]  w_shl;
  logic [10:0]  w_shr;

  assign w_exp  = i_bits[31:24];
  // Bit 23 (the compact sign bit) is deliberately excluded from the mantissa.
  assign w_mant = {233'b0, i_bits[22:0]};
  assign w_shl  = {w_exp, 3'b000} - 11'd24;
  assign w_shr  = 11'd24 - {w_exp, 3'b000};

  always_comb begin
    o_target = '0;
    if (w_exp <= 8'd3) begin
      o_target = w_mant >> w_shr;
    end else begin
      o_target = w_mant << w_shl;
    end
  end

endmodule

// File: rtl/nonce_scanner.sv
// Job sequencer: builds headers per nonce, hands them to the hash core one at a time,
// and compares each returned digest against the job's expanded target.
module nonce_scanner
  import mining_pkg::*;
#(
  parameter bit STOP_ON_FIND = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_version,
  input  logic [255:0]     job_prev_hash,
  input  logic [255:0]     job_merkle,
  input  logic [31:0]      job_time,
  input  logic [31:0]      job_bits,
  input  logic [31:0]      nonce_start,
  input  logic [31:0]      nonce_end,
  input  logic             abort,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [HDR_W-1:0] header,
  input  logic             dig_valid,
  input  logic [255:0]     digest,
  output logic             found,
  output logic [31:0]      found_nonce,
  output logic             done,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nx;
  logic [HDR_W-1:0] r_header;
  logic [31:0]      r_nonce;
  logic [31:0]      r_end;
  logic [31:0]      r_found_nonce;
  logic [31:0]      w_nonce_inc;
  logic [255:0]     r_target;
  logic [255:0]     r_digest;
  logic [255:0]     w_target;
  logic             r_hdr_valid;
  logic             r_found;
  logic             r_done;
  logic             r_busy;
  logic             r_job_ready;
  logic             w_load;
  logic             w_advance;
  logic             w_found_nx;
  logic             w_done_nx;
  logic             w_hit;
  logic             w_last;

  target_expand u_target_expand (
    .i_bits   (job_bits),
    .o_target (w_target)
  );

  assign w_nonce_inc = r_nonce + 32'd1;
  assign w_hit       = (r_digest <= r_target);
  assign w_last      = (r_nonce == r_end);

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_advance  = 1'b0;
    w_found_nx = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (job_valid) begin
          w_load     = 1'b1;
          w_state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          w_state_nx = ST_IDLE;
        end else if (hdr_ready) begin
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_state_nx = ST_IDLE;
        end else if (dig_valid) begin
          w_state_nx = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_found_nx = w_hit;
          if ((w_hit && STOP_ON_FIND) || w_last) begin
            w_done_nx  = 1'b1;
            w_state_nx = ST_IDLE;
          end else begin
            w_advance  = 1'b1;
            w_state_nx = ST_ISSUE;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_header      <= '0;
      r_nonce       <= '0;
      r_end         <= '0;
      r_found_nonce <= '0;
      r_target      <= '0;
      r_digest      <= '0;
      r_hdr_valid   <= 1'b0;
      r_found       <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_job_ready   <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_hdr_valid <= (w_state_nx == ST_ISSUE);
      r_busy      <= (w_state_nx != ST_IDLE);
      r_job_ready <= (w_state_nx == ST_IDLE);
      r_found     <= w_found_nx;
      r_done      <= w_done_nx;
      if (w_found_nx) begin
        r_found_nonce <= r_nonce;
      end
      // The header register doubles as the latched job fields; only its nonce slice moves.
      if (w_load) begin
        r_header <= build_header(job_version, job_prev_hash, job_merkle,
                                 job_time, job_bits, nonce_start);
        r_nonce  <= nonce_start;
        r_end    <= nonce_end;
        r_target <= w_target;
      end
      if (w_advance) begin
        r_nonce                    <= w_nonce_inc;
        r_header[NONCE_MSB -: 32]  <= bswap32(w_nonce_inc);
      end
      if ((r_state == ST_WAIT) && dig_valid) begin
        r_digest <= digest;
      end
    end
  end

  assign job_ready   = r_job_ready;
  assign hdr_valid   = r_hdr_valid;
  assign header      = r_header;
  assign found       = r_found;
  assign found_nonce = r_found_nonce;
  assign done        = r_done;
  assign busy        = r_busy;

endmodule
